// File: rtl/counter_updown_mod.sv
// counter_updown_mod
//   N-bit up/down modulo counter with programmable terminal value,
//   synchronous load, wrap or saturate at the terminal, a cascade carry
//   chain and a sticky overflow flag. Digits of a multi-digit counter are
//   built by chaining carry_out of one stage into carry_in of the next,
//   all stages sharing one clock.
//
// Ports
//   clock      counter clock, rising edge
//   reset      asynchronous, active-high; clears count and overflow
//   enable     count enable
//   carry_in   cascade input; tie high on the least-significant stage
//   updown     1 = count up, 0 = count down
//   load       synchronous load of data (wins over counting)
//   data       load value, taken unmodified even when above limit
//   limit      terminal value; count range is 0..limit
//   saturate   0 = wrap at the terminal, 1 = hold at the terminal
//   clear_ovf  synchronous clear of overflow
//   count      registered counter value
//   terminal   combinational: count is at the terminal for the direction
//   carry_out  combinational: this stage steps past its terminal this cycle
//   overflow   registered sticky flag: a wrap or clamp has occurred

module counter_updown_mod #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             carry_in,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] limit,
    input  logic             saturate,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             step;
    logic [WIDTH-1:0] count_next;
    logic             overflow_next;

    // Load suppresses stepping, so a load cycle never produces a carry.
    always_comb begin
        step = enable & carry_in & ~load;
    end

    // Up-terminal uses >= so a count loaded above limit is treated as
    // terminal and folds back into range on the next up step.
    always_comb begin
        if (updown) begin
            terminal = (count >= limit);
        end else begin
            terminal = (count == '0);
        end
    end

    always_comb begin
        carry_out = step & terminal;
    end

    // Terminal checks come before +1/-1, so neither wraps through 2**WIDTH.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = data;
        end else if (step) begin
            if (updown) begin
                if (terminal) begin
                    count_next = saturate ? limit : '0;
                end else begin
                    count_next = count + ONE;
                end
            end else begin
                if (terminal) begin
                    count_next = saturate ? '0 : limit;
                end else begin
                    count_next = count - ONE;
                end
            end
        end
    end

    // A wrap/clamp on the same edge as clear_ovf leaves the flag set.
    always_comb begin
        overflow_next = overflow;
        if (load) begin
            overflow_next = 1'b0;
        end else if (carry_out) begin
            overflow_next = 1'b1;
        end else if (clear_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous up/down counter with programmable terminal value, synchronous load, wrap or saturate mode, cascade carry chain and a sticky overflow flag. It generalises the team's 4-bit up/down counter into an N-bit modulo counter. It is intended for decade/BCD dividers, timers and multi-digit counter chains built from cascaded instances sharing one clock.

## Interface
- WIDTH, 8, counter width in bits (≥ 2)
- clock  in  1  counter clock; all state changes on the rising edge except reset
- reset  in  1  asynchronous, active-high; clears count and overflow
- enable  in  1  count enable
- carry_in  in  1  cascade input; tie high on the least-significant stage
- updown  in  1  1 = count up, 0 = count down
- load  in  1  synchronous load of data
- data  in  WIDTH  load value
- limit  in  WIDTH  terminal value; count range 0..limit
- saturate  in  1  0 = wrap at terminal, 1 = hold at terminal
- clear_ovf  in  1  synchronous clear of overflow
- count  out  WIDTH  registered counter value
- terminal  out  1  combinational: count at terminal for the current direction
- carry_out  out  1  combinational: this stage is stepping past its terminal
- overflow  out  1  registered sticky flag: a wrap or clamp has occurred

## Operation
- step = enable & carry_in & ~load.
- terminal = updown ? (count ≥ limit) : (count == 0).
- carry_out = step & terminal, in both modes; drives the next stage's carry_in.
- Priority at each rising edge: load > step > hold.
- Load: count ← data unmodified, including data > limit; overflow ← 0. Load also suppresses step and carry_out in the same cycle.
- Step up, not terminal: count ← count + 1.
- Step up, terminal: count ← 0 if saturate = 0, else count ← limit (this also clamps a count above limit down to limit).
- Step down, not terminal: count ← count − 1. This applies even when count > limit, so the counter decrements back into range.
- Step down, terminal (count = 0): count ← limit if saturate = 0, else count stays 0.
- Overflow is set on any edge where step & terminal. Otherwise, clear_ovf = 1 clears it. Set wins over clear_ovf in the same cycle.
- With limit = 0, count stays 0, terminal = 1, and every step asserts carry_out and sets overflow.
- Arithmetic is unsigned WIDTH-bit. No intermediate result exceeds WIDTH bits, because the terminal checks precede the +1 and −1.
- updown, limit and saturate may change on any cycle. They take effect on the next edge, and terminal and carry_out follow them combinationally.

## Timing
- Reset asserted: count = 0 and overflow = 0 immediately, independent of clock. terminal and carry_out then follow combinationally from count = 0.
- Reset deasserted: the first state change is on the next rising clock edge after deassertion. Reset asserted mid-count aborts the count with no partial step.
- Latency is one clock from load or step to the new count. overflow updates on the same edge as the wrap.
- terminal and carry_out have zero latency: they are combinational from count, limit, updown, enable, carry_in and load.
- Cascade timing:
  - The stage-k carry_out feeds the stage-k+1 carry_in on the same clock.
  - A ripple of N stages is a combinational path through N AND gates.
  - All stages update on the same edge, with no skew between digits.

## Test plan
- Decade up-count: limit = 9, updown = 1, saturate = 0, enable = 1, 12 clocks from reset. Required: count 1..9, 0, 1, 2. carry_out high only while count = 9. overflow set after the wrap.
- Down wrap and saturate:
  - limit = 5, updown = 0, start at 0, saturate = 0: one step gives count 5.
  - Repeat with saturate = 1: count stays 0, carry_out = 1, overflow = 1.
- Cascade: two instances with limit = 9 (ones stage carry_out → tens stage carry_in), 25 clocks up from reset. Required: tens:ones = 2:5. Tens stage increments only on edges where ones wraps 9→0.
- Load priority: count = 3, load = 1 with data = 200, limit = 9, enable = 1. Required:
  - count = 200 next cycle, carry_out = 0 during the load cycle, overflow cleared.
  - Next up step: terminal (200 ≥ 9), count wraps to 0.
  - A down step from 200 instead gives 199.
- Async reset mid-count: WIDTH = 8, count = 0x7F. Assert reset between clock edges. Required: count = 0 and overflow = 0 before the next edge. Hold reset over 2 edges with no change. Release reset: first increment on the next edge after release.
- Overflow clear race: assert clear_ovf on the same edge as a wrap. Required: overflow stays 1. Assert clear_ovf alone on the next edge: overflow = 0.
